// File: rtl/cyc_timing_monitor.sv
// cyc_timing_monitor: multi-channel clock-sampled setup/hold checker against one reference strobe
module cyc_timing_monitor #(
    parameter int CH        = 4,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CH-1:0]       data,
    input  logic                ref_sig,
    input  logic                clear,
    output logic [CH-1:0]       setup_viol,
    output logic [CH-1:0]       hold_viol,
    output logic [CH-1:0]       notifier,
    output logic [CH-1:0]       sticky,
    output logic [CH*CNT_W-1:0] setup_cnt,
    output logic [CH*CNT_W-1:0] hold_cnt
);
    localparam int AW = $clog2(SETUP_CYC + 2);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [AW-1:0] AMAX = AW'(SETUP_CYC + 1);
    localparam logic [AW-1:0] ALIM = AW'(SETUP_CYC - 1);
    localparam logic [HW-1:0] HLD  = HW'(HOLD_CYC);

    logic [CH-1:0]    d_q, chg, sv, hv;
    logic             r_q, armed, refev;
    logic [AW-1:0]    age [CH];
    logic [HW-1:0]    htmr;
    logic [CNT_W-1:0] scn [CH];
    logic [CNT_W-1:0] hcn [CH];

    // event detection, violation decode and next counter values (clear applied before increment)
    always_comb begin
        chg   = armed ? data ^ d_q : '0;
        refev = armed & ref_sig & ~r_q;
        sv    = '0;
        hv    = '0;
        for (int i = 0; i < CH; i++) begin
            sv[i]  = refev & enable & (chg[i] | (age[i] <= ALIM));
            hv[i]  = chg[i] & enable & (htmr != '0) & ~refev;
            scn[i] = clear ? '0 : setup_cnt[i*CNT_W +: CNT_W];
            hcn[i] = clear ? '0 : hold_cnt[i*CNT_W +: CNT_W];
            scn[i] = (sv[i] && scn[i] != '1) ? scn[i] + CNT_W'(1) : scn[i];
            hcn[i] = (hv[i] && hcn[i] != '1) ? hcn[i] + CNT_W'(1) : hcn[i];
        end
    end

    // sampled history, ages, hold window and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q        <= '0;
            r_q        <= 1'b1;
            armed      <= 1'b0;
            htmr       <= '0;
            setup_viol <= '0;
            hold_viol  <= '0;
            notifier   <= '0;
            sticky     <= '0;
            setup_cnt  <= '0;
            hold_cnt   <= '0;
            for (int i = 0; i < CH; i++) age[i] <= AMAX;
        end else begin
            d_q        <= data;
            r_q        <= ref_sig;
            armed      <= 1'b1;
            htmr       <= (refev & enable) ? HLD : (htmr != '0 ? htmr - HW'(1) : htmr);
            setup_viol <= sv;
            hold_viol  <= hv;
            notifier   <= notifier ^ (sv | hv);
            sticky     <= (clear ? '0 : sticky) | sv | hv;
            for (int i = 0; i < CH; i++) begin
                age[i]                      <= chg[i] ? '0 : (age[i] == AMAX ? AMAX : age[i] + AW'(1));
                setup_cnt[i*CNT_W +: CNT_W] <= scn[i];
                hold_cnt[i*CNT_W +: CNT_W]  <= hcn[i];
            end
        end
    end
endmodule

// File: tb/tb_cyc_timing_monitor.sv
// tb_cyc_timing_monitor: directed setup/hold scenarios with hand-computed expectations
module tb_cyc_timing_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  data = '0;
    logic        ref_sig = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  sv0, hv0, nt0, st0, sv1, hv1, nt1, st1;
    logic [31:0] sc0, hc0;
    logic [7:0]  sc1, hc1;
    int          checks = 0;
    int          errors = 0;

    cyc_timing_monitor u0 (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .ref_sig(ref_sig), .clear(clear),
        .setup_viol(sv0), .hold_viol(hv0), .notifier(nt0), .sticky(st0),
        .setup_cnt(sc0), .hold_cnt(hc0)
    );

    cyc_timing_monitor #(.CNT_W(2), .HOLD_CYC(2)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .ref_sig(ref_sig), .clear(clear),
        .setup_viol(sv1), .hold_viol(hv1), .notifier(nt1), .sticky(st1),
        .setup_cnt(sc1), .hold_cnt(hc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2;
        chk("rst_sv", sv0, 0);
        chk("rst_nt", nt0, 0);
        chk("rst_cnt", sc0 | hc0, 0);
        idle(2);
        rst = 1'b0;
        idle(3);
        // change then ref one edge later
        data = 4'b0001; tick();
        chk("t1_pre", sv0, 0);
        ref_sig = 1'b1; tick();
        chk("t1_sv", sv0, 4'b0001);
        chk("t1_nt", nt0, 4'b0001);
        chk("t1_st", st0, 4'b0001);
        chk("t1_sc", sc0, 32'h1);
        chk("t1_hc", hc0, 0);
        ref_sig = 1'b0; tick();
        chk("t1_pulse", sv0, 0);
        // ref SETUP_CYC edges after change: violation
        idle(3);
        data = 4'b0000; tick();
        tick();
        ref_sig = 1'b1; tick();
        chk("t2_sv", sv0, 4'b0001);
        chk("t2_sc", sc0, 32'h2);
        chk("t2_nt", nt0, 0);
        ref_sig = 1'b0; tick();
        // ref SETUP_CYC+1 edges after change: clean
        idle(3);
        data = 4'b0001; tick();
        idle(2);
        ref_sig = 1'b1; tick();
        chk("t2b_sv", sv0, 0);
        chk("t2b_sc", sc0, 32'h2);
        ref_sig = 1'b0; tick();
        // hold violation one edge after ref
        idle(3);
        ref_sig = 1'b1; tick();
        ref_sig = 1'b0; data = 4'b0011; tick();
        chk("t3_hv", hv0, 4'b0010);
        chk("t3_hc", hc0, 32'h100);
        chk("t3_sv", sv0, 0);
        chk("t3_nt", nt0, 4'b0010);
        chk("t3_st", st0, 4'b0011);
        tick();
        chk("t3_pulse", hv0, 0);
        idle(3);
        ref_sig = 1'b1; tick();
        ref_sig = 1'b0; tick();
        data = 4'b0001; tick();
        chk("t3b_hv", hv0, 0);
        chk("t3b_hc", hc0, 32'h100);
        // change coinciding with a new ref inside an open window (u1 window is 2)
        idle(3);
        ref_sig = 1'b1; tick();
        ref_sig = 1'b0; tick();
        ref_sig = 1'b1; data = 4'b0101; tick();
        chk("t4_sv", sv0, 4'b0100);
        chk("t4_hv", hv0, 0);
        chk("t4_sc", sc0, 32'h0001_0002);
        chk("t4_nt", nt0, 4'b0110);
        chk("t4_u1_sv", sv1[2], 1);
        chk("t4_u1_hv", hv1[2], 0);
        chk("t4_u1_hc", hc1[5:4], 0);
        ref_sig = 1'b0; tick();
        // five setup violations on ch3: saturate the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            idle(3);
            data[3] = ~data[3]; tick();
            ref_sig = 1'b1; tick();
            ref_sig = 1'b0; tick();
        end
        chk("t5_u1_sat", sc1[7:6], 3);
        chk("t5_u0_sc3", sc0[31:24], 5);
        idle(3);
        data[3] = ~data[3]; tick();
        ref_sig = 1'b1; clear = 1'b1; tick();
        chk("t5_u1_clr", sc1[7:6], 1);
        chk("t5_u1_st", st1[3], 1);
        chk("t5_sc", sc0, 32'h0100_0000);
        chk("t5_hc", hc0, 0);
        chk("t5_st", st0, 4'b1000);
        chk("t5_nt", nt0, 4'b0110);
        clear = 1'b0; ref_sig = 1'b0; tick();
        // disabled: violating patterns are ignored
        idle(3);
        enable = 1'b0;
        data[0] = ~data[0]; tick();
        ref_sig = 1'b1; tick();
        chk("t6_sv", sv0, 0);
        chk("t6_sc", sc0, 32'h0100_0000);
        chk("t6_st", st0, 4'b1000);
        ref_sig = 1'b0; data[1] = ~data[1]; tick();
        chk("t6_hv", hv0, 0);
        chk("t6_hc", hc0, 0);
        enable = 1'b1;
        idle(3);
        // reset inside an open hold window, ref held high through release
        ref_sig = 1'b1; tick();
        chk("t7_sv", sv0, 0);
        rst = 1'b1; #1;
        chk("t7_rst_st", st0, 0);
        chk("t7_rst_nt", nt0, 0);
        chk("t7_rst_cnt", sc0 | hc0, 0);
        data[2] = ~data[2];
        idle(2);
        rst = 1'b0;
        tick();
        chk("t7_first", sv0 | hv0, 0);
        tick();
        data[0] = ~data[0]; tick();
        chk("t7_hv", hv0, 0);
        chk("t7_sv2", sv0, 0);
        chk("t7_st", st0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
